// File: rtl/lisa_qspi_burst_reader.sv
// lisa_qspi_burst_reader
//   Client-side read sequencer for one QSPI arbiter client port. A single
//   long read command (start byte address + up to 255 16-bit words) is split
//   into arbiter transfers. Each transfer is no longer than MAX_CHUNK words
//   and never crosses a PAGE_BYTES boundary. Returned words are buffered in
//   a small FIFO for a valid/ready consumer.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   start              one-cycle command strobe (sampled in IDLE only)
//   start_addr         byte address of first word (bit 0 ignored)
//   word_count         number of words, 0 completes immediately
//   ce_sel             chip select, latched at start
//   abort              end the command early
//   busy, done         command in progress / one-cycle completion pulse
//   aborted            qualifies done: command ended by abort
//   rd_data, rd_valid  FIFO head word / FIFO not empty
//   rd_ready           consumer pop
//   q_*                arbiter client port (request, word handshake, done)
module lisa_qspi_burst_reader #(
  parameter int CHIP_SELECTS = 2,
  parameter int MAX_CHUNK    = 8,
  parameter int PAGE_BYTES   = 256,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [23:0]             start_addr,
  input  logic [7:0]              word_count,
  input  logic [CHIP_SELECTS-1:0] ce_sel,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic [15:0]             rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [23:0]             q_addr,
  input  logic [15:0]             q_rdata,
  output logic [15:0]             q_wdata,
  output logic [1:0]              q_wstrb,
  input  logic                    q_ready,
  output logic                    q_ready_ack,
  input  logic                    q_xfer_done,
  output logic                    q_valid,
  output logic [3:0]              q_xfer_len,
  output logic [CHIP_SELECTS-1:0] q_ce_ctrl
);

  localparam int             AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]    FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [23:0]    PAGE_MASK  = 24'(PAGE_BYTES - 1);
  localparam logic [7:0]     MAX_CHUNK8 = 8'(MAX_CHUNK);

  typedef enum logic [2:0] {IDLE, ISSUE, XFER, DRAIN, FINISH} state_t;

  state_t                  state;
  logic [23:0]             addr;
  logic [7:0]              rem;
  logic [CHIP_SELECTS-1:0] cs;
  logic                    aborting;
  logic                    discard;
  logic                    valid_r;
  logic                    done_r;
  logic                    aborted_r;
  logic [23:0]             q_addr_r;
  logic [3:0]              q_len_r;

  logic [15:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;

  logic                    full;
  logic                    empty;
  logic                    drop;
  logic                    ack;
  logic                    push;
  logic                    pop;
  logic                    stop_issue;
  logic [7:0]              rem_after;

  // Words in the next transfer: min(remaining, MAX_CHUNK, words left in page).
  function automatic logic [3:0] chunk_words(input logic [23:0] a, input logic [7:0] r);
    logic [7:0]  lim;
    logic [24:0] page_left;
    lim       = (r > MAX_CHUNK8) ? MAX_CHUNK8 : r;
    page_left = (25'(PAGE_BYTES) - {1'b0, a & PAGE_MASK}) >> 1;
    if (page_left < 25'(lim)) chunk_words = page_left[3:0];
    else                      chunk_words = lim[3:0];
  endfunction

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // An abort arriving this cycle already discards the word acked with it.
  assign drop        = discard | abort;
  assign ack         = (state == XFER) & q_ready & (rem != 8'd0) & (~full | drop);
  assign push        = ack & ~drop;
  assign pop         = ~empty & rd_ready;
  assign rem_after   = ack ? (rem - 8'd1) : rem;
  assign stop_issue  = aborting | abort;

  assign busy        = (state != IDLE);
  assign done        = done_r;
  assign aborted     = aborted_r;
  assign rd_valid    = ~empty;
  assign rd_data     = empty ? 16'h0000 : mem[rd_ptr];
  assign q_addr      = q_addr_r;
  assign q_xfer_len  = q_len_r;
  assign q_ce_ctrl   = cs;
  assign q_wdata     = 16'h0000;
  assign q_wstrb     = 2'b00;
  assign q_ready_ack = ack;
  // Request is withdrawn in the same cycle the arbiter signals completion.
  assign q_valid     = valid_r & ~q_xfer_done;

  // Control: FSM, flags, FIFO pointers and registered port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cs        <= '0;
      aborting  <= 1'b0;
      discard   <= 1'b0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      q_addr_r  <= 24'h0;
      q_len_r   <= 4'h0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      case (state)
        IDLE: begin
          if (start) begin
            cs    <= ce_sel;
            state <= (word_count == 8'd0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          q_addr_r <= addr;
          q_len_r  <= chunk_words(addr, rem);
          valid_r  <= 1'b1;
          state    <= XFER;
          if (abort) begin
            aborting <= 1'b1;
            discard  <= 1'b1;
          end
        end
        XFER: begin
          if (abort) begin
            aborting <= 1'b1;
            discard  <= 1'b1;
          end
          if (q_xfer_done) begin
            valid_r <= 1'b0;
            if ((rem_after != 8'd0) && !stop_issue) begin
              state <= ISSUE;
            end else begin
              state <= DRAIN;
              // Aborted commands deliver nothing still buffered.
              if (stop_issue) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
              end
            end
          end
        end
        DRAIN: begin
          if (empty) state <= FINISH;
        end
        FINISH: begin
          done_r    <= 1'b1;
          aborted_r <= aborting;
          aborting  <= 1'b0;
          discard   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: command address/remaining count and FIFO storage.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      addr <= start_addr & 24'hFFFFFE;
      rem  <= word_count;
    end else if (ack) begin
      addr <= addr + 24'd2;
      rem  <= rem - 8'd1;
    end
    if (push) mem[wr_ptr] <= q_rdata;
  end

endmodule

// File: tb/tb_lisa_qspi_burst_reader.sv
`timescale 1ns/1ps
module tb_lisa_qspi_burst_reader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, rd_ready, q_ready, q_xfer_done;
  logic [23:0] start_addr;
  logic [7:0]  word_count;
  logic [1:0]  ce_sel;
  logic        busy, done, aborted, rd_valid, q_ready_ack, q_valid;
  logic [15:0] rd_data, q_rdata, q_wdata;
  logic [1:0]  q_wstrb, q_ce_ctrl;
  logic [23:0] q_addr;
  logic [3:0]  q_xfer_len;

  lisa_qspi_burst_reader #(
    .CHIP_SELECTS(2), .MAX_CHUNK(8), .PAGE_BYTES(256), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .ce_sel(ce_sel), .abort(abort), .busy(busy),
    .done(done), .aborted(aborted), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .q_addr(q_addr), .q_rdata(q_rdata), .q_wdata(q_wdata),
    .q_wstrb(q_wstrb), .q_ready(q_ready), .q_ready_ack(q_ready_ack),
    .q_xfer_done(q_xfer_done), .q_valid(q_valid), .q_xfer_len(q_xfer_len),
    .q_ce_ctrl(q_ce_ctrl)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          acks     = 0;
  int          rd_mode  = 1;     // 0: stall, 1: always ready, 2: random
  bit          same_ok  = 1'b0;  // allow q_xfer_done together with last ack
  logic [15:0] dseed    = 16'h0;
  logic [23:0] cmd_base = 24'h0;

  logic [23:0] xf_addr[$];
  logic [3:0]  xf_len[$];
  logic [1:0]  xf_ce[$];
  logic [15:0] got[$];
  logic [23:0] ex_addr[$];
  int          ex_len[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word i of the current command (address relative to its base) is dseed+i+1.
  function automatic logic [15:0] data_of(input logic [23:0] a);
    logic [23:0] d;
    d = a - cmd_base;
    return dseed + d[16:1] + 16'd1;
  endfunction

  // Reference transfer list: greedy split by remaining count, chunk limit, page end.
  task automatic build_model(input logic [23:0] a0, input int cnt);
    logic [23:0] a;
    int r, pl, c;
    ex_addr.delete(); ex_len.delete();
    a = a0 & 24'hFFFFFE;
    r = cnt;
    while (r > 0) begin
      pl = (256 - int'(a % 24'd256)) / 2;
      c  = r;
      if (c > 8)  c = 8;
      if (c > pl) c = pl;
      ex_addr.push_back(a);
      ex_len.push_back(c);
      a = a + 24'(2 * c);
      r = r - c;
    end
  endtask

  task automatic run_start(input logic [23:0] a, input logic [7:0] n, input logic [1:0] cs);
    @(negedge clk); #2;
    xf_addr.delete(); xf_len.delete(); xf_ce.delete(); got.delete();
    acks = 0;
    cmd_base = a & 24'hFFFFFE;
    start_addr = a; word_count = n; ce_sel = cs; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output logic ab, input int budget);
    bit seen;
    seen = 1'b0;
    ab = 1'bx;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #2;
      if (done === 1'b1) begin
        seen = 1'b1;
        ab = aborted;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) chk("busy_low_at_done", 32'(busy), 32'd0);
  endtask

  task automatic check_cmd(input string tag, input int cnt, input logic ab,
                           input logic ab_exp, input logic [1:0] cs);
    chk({tag, "_nxfer"}, 32'(xf_addr.size()), 32'(ex_addr.size()));
    for (int i = 0; i < ex_addr.size() && i < xf_addr.size(); i++) begin
      chk({tag, "_xaddr"}, 32'(xf_addr[i]), 32'(ex_addr[i]));
      chk({tag, "_xlen"},  32'(xf_len[i]),  32'(ex_len[i]));
      chk({tag, "_xce"},   32'(xf_ce[i]),   32'(cs));
    end
    chk({tag, "_nwords"}, 32'(got.size()), 32'(cnt));
    for (int i = 0; i < cnt && i < got.size(); i++)
      chk({tag, "_word"}, 32'(got[i]), 32'(dseed + 16'(i) + 16'd1));
    chk({tag, "_aborted"}, 32'(ab), 32'(ab_exp));
    chk({tag, "_fifo_empty"}, 32'(rd_valid), 32'd0);
  endtask

  // Arbiter model: latches each request, offers its words one at a time.
  initial begin : arbiter
    logic [23:0] ta;
    int          tl;
    bit          kill, gotw, same;
    q_ready = 1'b0; q_xfer_done = 1'b0; q_rdata = 16'h0;
    forever begin
      @(negedge clk);
      q_xfer_done = 1'b0;
      if (rst_n === 1'b1 && q_valid === 1'b1) begin
        ta = q_addr;
        tl = int'(q_xfer_len);
        xf_addr.push_back(q_addr); xf_len.push_back(q_xfer_len); xf_ce.push_back(q_ce_ctrl);
        kill = 1'b0; same = 1'b0;
        for (int i = 0; i < tl && !kill; i++) begin
          same = (i == tl - 1) && same_ok && ($urandom_range(0, 1) == 1);
          gotw = 1'b0;
          while (!gotw && !kill) begin
            q_ready = 1'b1;
            q_rdata = data_of(ta);
            #4;
            if (rst_n !== 1'b1) kill = 1'b1;
            else begin
              chk("q_valid_held", 32'(q_valid), 32'd1);
              if (q_ready_ack === 1'b1) begin
                gotw = 1'b1;
                acks++;
                if (same) q_xfer_done = 1'b1;
              end
            end
            @(negedge clk);
          end
          ta = ta + 24'd2;
        end
        q_ready = 1'b0;
        if (kill || same) q_xfer_done = 1'b0;
        else begin
          q_xfer_done = 1'b1;
          @(negedge clk);
          q_xfer_done = 1'b0;
        end
      end
    end
  end

  // Consumer model: records every popped word.
  initial begin : consumer
    rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_mode == 0)      rd_ready = 1'b0;
      else if (rd_mode == 1) rd_ready = 1'b1;
      else                   rd_ready = ($urandom_range(0, 1) == 1);
      #4;
      if (rst_n === 1'b1 && rd_valid === 1'b1 && rd_ready) got.push_back(rd_data);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=still_running required=finished");
    $fatal(1);
  end

  initial begin : main
    logic        ab;
    logic [23:0] ra;
    int          rc;
    logic [1:0]  rcs;
    bit          reached;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = 24'h0; word_count = 8'h0; ce_sel = 2'b00;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_q_addr", 32'(q_addr), 32'd0);
    chk("rst_q_xfer_len", 32'(q_xfer_len), 32'd0);
    chk("rst_q_ce_ctrl", 32'(q_ce_ctrl), 32'd0);
    chk("rst_q_ready_ack", 32'(q_ready_ack), 32'd0);
    chk("rst_q_wdata", 32'(q_wdata), 32'd0);
    chk("rst_q_wstrb", 32'(q_wstrb), 32'd0);
    rst_n = 1'b1;

    // Basic three-word read
    dseed = 16'hA000; rd_mode = 1; same_ok = 1'b0;
    build_model(24'h000100, 3);
    run_start(24'h000100, 8'd3, 2'b01);
    wait_done(ab, 200);
    check_cmd("basic", 3, ab, 1'b0, 2'b01);

    // Chunking across a page boundary
    dseed = 16'h1000; rd_mode = 2; same_ok = 1'b1;
    build_model(24'h0000F8, 20);
    run_start(24'h0000F8, 8'd20, 2'b10);
    wait_done(ab, 1000);
    check_cmd("chunk", 20, ab, 1'b0, 2'b10);

    // Backpressure: consumer stalled
    dseed = 16'h2000; rd_mode = 0; same_ok = 1'b0;
    build_model(24'h000400, 10);
    run_start(24'h000400, 8'd10, 2'b01);
    repeat (30) @(negedge clk);
    #2;
    chk("bp_acks", 32'(acks), 32'd4);
    chk("bp_q_ready_held", 32'(q_ready), 32'd1);
    chk("bp_no_ack", 32'(q_ready_ack), 32'd0);
    chk("bp_rd_valid", 32'(rd_valid), 32'd1);
    rd_mode = 1;
    wait_done(ab, 1000);
    check_cmd("bp", 10, ab, 1'b0, 2'b01);

    // Abort after the 5th word
    dseed = 16'h3000; rd_mode = 1; same_ok = 1'b0;
    run_start(24'h000200, 8'd30, 2'b11);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk); #2;
      if (acks >= 5) reached = 1'b1;
    end
    chk("abort_reached_5", 32'(reached), 32'd1);
    abort = 1'b1;
    @(negedge clk); #2;
    abort = 1'b0;
    wait_done(ab, 500);
    chk("abort_nxfer", 32'(xf_addr.size()), 32'd1);
    if (xf_addr.size() > 0) begin
      chk("abort_xaddr", 32'(xf_addr[0]), 32'h000200);
      chk("abort_xlen", 32'(xf_len[0]), 32'd8);
    end
    chk("abort_acks", 32'(acks), 32'd8);
    chk("abort_nwords", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size() && i < 5; i++)
      chk("abort_word", 32'(got[i]), 32'(dseed + 16'(i) + 16'd1));
    chk("abort_flag", 32'(ab), 32'd1);
    chk("abort_fifo_flushed", 32'(rd_valid), 32'd0);
    repeat (10) @(negedge clk);
    #2;
    chk("abort_no_more_xfer", 32'(xf_addr.size()), 32'd1);
    chk("abort_idle", 32'(busy), 32'd0);

    // Zero word count
    rd_mode = 1;
    run_start(24'h000500, 8'd0, 2'b10);
    chk("zero_done_early", 32'(done), 32'd0);
    @(negedge clk); #2;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_aborted", 32'(aborted), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_nxfer", 32'(xf_addr.size()), 32'd0);

    // Odd start address
    dseed = 16'h5000; rd_mode = 1;
    build_model(24'h000101, 1);
    run_start(24'h000101, 8'd1, 2'b11);
    wait_done(ab, 200);
    check_cmd("odd", 1, ab, 1'b0, 2'b11);

    // Address wrap at the top of the 24-bit space
    dseed = 16'h6000; rd_mode = 2; same_ok = 1'b1;
    build_model(24'hFFFFF0, 20);
    run_start(24'hFFFFF0, 8'd20, 2'b01);
    wait_done(ab, 1000);
    check_cmd("wrap", 20, ab, 1'b0, 2'b01);

    // Reset in the middle of a transfer
    dseed = 16'h7000; rd_mode = 1; same_ok = 1'b0;
    run_start(24'h000300, 8'd20, 2'b01);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk); #2;
      if (acks >= 2) reached = 1'b1;
    end
    chk("rstmid_reached", 32'(reached), 32'd1);
    rst_n = 1'b0;
    @(negedge clk); #2;
    chk("rstmid_q_valid", 32'(q_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_rd_valid", 32'(rd_valid), 32'd0);
    chk("rstmid_q_ce_ctrl", 32'(q_ce_ctrl), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    dseed = 16'h7100; rd_mode = 2; same_ok = 1'b1;
    build_model(24'h0003F0, 12);
    run_start(24'h0003F0, 8'd12, 2'b10);
    wait_done(ab, 1000);
    check_cmd("after_rst", 12, ab, 1'b0, 2'b10);

    // Randomized commands
    for (int k = 0; k < 6; k++) begin
      ra  = 24'($urandom);
      rc  = int'($urandom_range(1, 40));
      rcs = 2'($urandom_range(0, 3));
      dseed = 16'($urandom);
      rd_mode = 2; same_ok = 1'b1;
      build_model(ra, rc);
      run_start(ra, 8'(rc), rcs);
      wait_done(ab, 3000);
      check_cmd("rand", rc, ab, 1'b0, rcs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
